sl3p_axis_traffic_gen: RTL and testbench

Synthesizable, LANES-parametrised AXI-stream traffic source for the SerialLite III TX user port. It replaces bench-only `$random` stimulus with an LFSR and adds selectable modes, burst control, frame limiting and statistics counters. It drives `tx_tdata/tx_tkeep/tx_tlast/tx_vcid/tx_flit_type` of an sl3p core, so hardware loopback tests produce the same lane-0 `'A'..'Z'` sequence that the RX checkers expect.

---
 rtl/sl3p_axis_traffic_gen.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sl3p_axis_traffic_gen.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl3p_axis_traffic_gen.sv
// LFSR-driven AXI-stream traffic source for the SerialLite III TX user port.
// Random / fixed-pattern / burst / idle modes with frame limiting and saturating counters.
module sl3p_axis_traffic_gen #(
  parameter int unsigned LANES = 2,
  parameter logic [31:0] SEED  = 32'h1234_5678,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  tx_clk,
  input  logic                  tx_arst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [7:0]            burst_len,
  input  logic [CNT_W-1:0]      frame_limit,
  input  logic                  tx_tready,
  output logic                  tx_tvalid,
  output logic [LANES*64-1:0]   tx_tdata,
  output logic [LANES*8-1:0]    tx_tkeep,
  output logic                  tx_tlast,
  output logic [5:0]            tx_vcid,
  output logic [1:0]            tx_flit_type,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      word_cnt,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int unsigned DW   = LANES * 64;
  localparam int unsigned KW   = LANES * 8;
  localparam logic [31:0] Poly = 32'h8020_0003;

  // Lane words with the first character in byte 0.
  localparam logic [63:0] WordData    = 64'h2020_2020_6174_6164; // "data    "
  localparam logic [63:0] WordFinal   = 64'h6477_206c_616e_6966; // "final wd"
  localparam logic [63:0] WordCharlie = 64'h2065_696c_7261_6863; // "charlie "
  localparam logic [63:0] WordDelta   = 64'h2020_2061_746c_6564; // "delta   "

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [2:0] {BtNone, BtData, BtFinal, BtEmpty, BtPattern} beat_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d, lfsr_nxt;
  logic [4:0]       ser_q, ser_d, ser_nxt;
  logic [5:0]       vcid_q, vcid_d;
  logic [1:0]       ft_q, ft_d;
  logic [1:0]       fmode_q, fmode_d;
  logic [7:0]       fbl_q, fbl_d;
  logic [7:0]       idx_q, idx_d;
  logic             tvalid_q, tvalid_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic [KW-1:0]    tkeep_q, tkeep_d;
  logic             tlast_q, tlast_d;
  logic             is_data_q, is_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  logic             accept;
  logic             limit_hit;
  logic             new_frame;
  logic             decide;
  logic [1:0]       dec_mode;
  logic [7:0]       dec_bl;
  logic [7:0]       dec_idx;
  logic [CNT_W-1:0] fcnt_inc;
  logic [1:0]       rb;
  beat_e            beat_sel;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ({1'b0, s[31:1]} ^ Poly) : {1'b0, s[31:1]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr_q);
  assign rb       = lfsr_nxt[1:0];

  // Decide whether a new beat is chosen this cycle and which frame context it uses.
  always_comb begin
    accept    = tvalid_q & tx_tready;
    fcnt_inc  = sat_inc(fcnt_q);
    limit_hit = (frame_limit != '0) && (fcnt_inc == frame_limit);
    new_frame = 1'b0;
    decide    = 1'b0;
    dec_mode  = fmode_q;
    dec_bl    = fbl_q;
    dec_idx   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (enable && (mode != 2'd3)) new_frame = 1'b1;
      end
      StRun: begin
        if (accept) begin
          if (!tlast_q) begin
            decide  = 1'b1;
            dec_idx = idx_q + 8'd1;
          end else if (!limit_hit && enable && (mode != 2'd3)) begin
            new_frame = 1'b1;
          end
        end else if (!tvalid_q) begin
          // Mode-0 bubble: re-decide within the same frame.
          decide = 1'b1;
        end
      end
      default: ;
    endcase
    if (new_frame) begin
      decide   = 1'b1;
      dec_mode = mode;
      dec_bl   = burst_len;
      dec_idx  = '0;
    end
  end

  always_comb begin
    beat_sel = BtNone;
    unique case (dec_mode)
      2'd0: begin
        unique case (rb)
          2'b00: beat_sel = BtNone;
          2'b01: beat_sel = BtData;
          2'b10: beat_sel = BtFinal;
          2'b11: beat_sel = BtEmpty;
        endcase
      end
      2'd1:    beat_sel = (dec_idx == 8'd0) ? BtPattern : BtEmpty;
      2'd2:    beat_sel = (dec_idx < dec_bl) ? BtData : BtFinal;
      default: beat_sel = BtNone;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    vcid_d    = vcid_q;
    ft_d      = ft_q;
    fmode_d   = fmode_q;
    fbl_d     = fbl_q;
    idx_d     = idx_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    is_data_d = is_data_q;
    wcnt_d    = wcnt_q;
    fcnt_d    = fcnt_q;

    ser_nxt = ser_q;
    if (accept && is_data_q) ser_nxt = (ser_q == 5'd25) ? 5'd0 : ser_q + 5'd1;
    ser_d = ser_nxt;

    unique case (state_q)
      StIdle: begin
        if (new_frame) begin
          state_d = StRun;
          wcnt_d  = '0;
          fcnt_d  = '0;
        end
      end
      StRun: begin
        if (accept) begin
          wcnt_d = sat_inc(wcnt_q);
          if (tlast_q) begin
            fcnt_d = fcnt_inc;
            vcid_d = vcid_q + 6'd1;
            ft_d   = ft_q + 2'd1;
            if (limit_hit)       state_d = StDone;
            else if (!new_frame) state_d = StIdle;
          end
        end
      end
      StDone: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (decide) begin
      lfsr_d    = lfsr_nxt;
      fmode_d   = dec_mode;
      fbl_d     = dec_bl;
      idx_d     = dec_idx;
      tvalid_d  = 1'b1;
      tdata_d   = '0;
      tkeep_d   = '0;
      tlast_d   = 1'b0;
      is_data_d = 1'b0;
      unique case (beat_sel)
        BtData: begin
          for (int unsigned l = 0; l < LANES; l++) tdata_d[l*64 +: 64] = WordData;
          tdata_d[7:0] = 8'h41 + {3'b000, ser_nxt};
          tkeep_d      = '1;
          is_data_d    = 1'b1;
        end
        BtFinal: begin
          tdata_d[63:0] = WordFinal;
          tkeep_d[7:0]  = 8'hff;
          tlast_d       = 1'b1;
        end
        BtEmpty: tlast_d = 1'b1;
        BtPattern: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            tdata_d[l*64 +: 64] = (l == 0) ? WordCharlie : WordDelta;
          end
          tkeep_d = '1;
        end
        default: tvalid_d = 1'b0;
      endcase
    end else if (accept) begin
      // Final beat accepted and RUN is being left.
      tvalid_d  = 1'b0;
      tdata_d   = '0;
      tkeep_d   = '0;
      tlast_d   = 1'b0;
      is_data_d = 1'b0;
    end

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge tx_clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      state_q   <= StIdle;
      lfsr_q    <= SEED;
      ser_q     <= '0;
      vcid_q    <= '0;
      ft_q      <= '0;
      fmode_q   <= '0;
      fbl_q     <= '0;
      idx_q     <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      is_data_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wcnt_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ser_q     <= ser_d;
      vcid_q    <= vcid_d;
      ft_q      <= ft_d;
      fmode_q   <= fmode_d;
      fbl_q     <= fbl_d;
      idx_q     <= idx_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      is_data_q <= is_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wcnt_q    <= wcnt_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign tx_tvalid    = tvalid_q;
  assign tx_tdata     = tdata_q;
  assign tx_tkeep     = tkeep_q;
  assign tx_tlast     = tlast_q;
  assign tx_vcid      = vcid_q;
  assign tx_flit_type = ft_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_cnt     = wcnt_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_sl3p_axis_traffic_gen.sv
// Scoreboard bench for sl3p_axis_traffic_gen: a frame-level model queues expected beats,
// a negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_sl3p_axis_traffic_gen;

  localparam int unsigned LANES = 2;
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] SEED  = 32'h1234_5678;
  localparam int          MAXC  = 15;
  localparam int          BOUND = 3000;

  localparam int KData = 0, KFinal = 1, KEmpty = 2, KPattern = 3;

  logic               tx_clk;
  logic               tx_arst_n;
  logic               enable;
  logic [1:0]         mode;
  logic [7:0]         burst_len;
  logic [CNT_W-1:0]   frame_limit;
  logic               tx_tready;
  logic               tx_tvalid;
  logic [127:0]       tx_tdata;
  logic [15:0]        tx_tkeep;
  logic               tx_tlast;
  logic [5:0]         tx_vcid;
  logic [1:0]         tx_flit_type;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   frame_cnt;

  sl3p_axis_traffic_gen #(
    .LANES (LANES),
    .SEED  (SEED),
    .CNT_W (CNT_W)
  ) dut (
    .tx_clk       (tx_clk),
    .tx_arst_n    (tx_arst_n),
    .enable       (enable),
    .mode         (mode),
    .burst_len    (burst_len),
    .frame_limit  (frame_limit),
    .tx_tready    (tx_tready),
    .tx_tvalid    (tx_tvalid),
    .tx_tdata     (tx_tdata),
    .tx_tkeep     (tx_tkeep),
    .tx_tlast     (tx_tlast),
    .tx_vcid      (tx_vcid),
    .tx_flit_type (tx_flit_type),
    .busy         (busy),
    .done         (done),
    .word_cnt     (word_cnt),
    .frame_cnt    (frame_cnt)
  );

  initial begin
    tx_clk = 1'b0;
    forever #5 tx_clk = ~tx_clk;
  end

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [5:0]   vcid;
    logic [1:0]   ft;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;

  int n_cmp = 0;
  int n_fail = 0;
  int beats_seen = 0;
  int frames_seen = 0;

  // Reference model state
  logic [31:0] m_lfsr;
  int          m_ser;
  logic [5:0]  m_vcid;
  logic [1:0]  m_ft;

  logic bp_rand = 1'b0;
  logic stall_on_b = 1'b0;
  int   stall_left = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_word(input string s);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = s[i];
    return w;
  endfunction

  function automatic int min_sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_ser  = 0;
    m_vcid = '0;
    m_ft   = '0;
  endtask

  task automatic m_step();
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
  endtask

  task automatic push_beat(input int kind);
    beat_t b;
    b.data = '0;
    b.keep = '0;
    b.last = 1'b0;
    b.vcid = m_vcid;
    b.ft   = m_ft;
    case (kind)
      KData: begin
        for (int l = 0; l < LANES; l++) b.data[l*64 +: 64] = lane_word("data    ");
        b.data[7:0] = 8'(65 + m_ser);
        b.keep = '1;
        m_ser = (m_ser + 1) % 26;
      end
      KFinal: begin
        b.data[63:0] = lane_word("final wd");
        b.keep[7:0]  = 8'hff;
        b.last       = 1'b1;
      end
      KEmpty: b.last = 1'b1;
      default: begin
        b.data[63:0]   = lane_word("charlie ");
        b.data[127:64] = lane_word("delta   ");
        b.keep = '1;
      end
    endcase
    exp_q.push_back(b);
  endtask

  // One whole frame of expected beats; every beat choice advances the LFSR once.
  task automatic gen_frame(input logic [1:0] md, input int bl);
    logic [1:0] rb;
    if (md == 2'd2) begin
      for (int i = 0; i < bl; i++) begin
        m_step();
        push_beat(KData);
      end
      m_step();
      push_beat(KFinal);
    end else if (md == 2'd1) begin
      m_step();
      push_beat(KPattern);
      m_step();
      push_beat(KEmpty);
    end else begin
      do begin
        m_step();
        rb = m_lfsr[1:0];
        if (rb == 2'b01) push_beat(KData);
        else if (rb == 2'b10) push_beat(KFinal);
        else if (rb == 2'b11) push_beat(KEmpty);
      end while (rb < 2'b10);
    end
    m_vcid = m_vcid + 6'd1;
    m_ft   = m_ft + 2'd1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_tvalid"}, tx_tvalid, 0);
    check({tag, "_tdata"}, tx_tdata, 0);
    check({tag, "_tkeep"}, tx_tkeep, 0);
    check({tag, "_tlast"}, tx_tlast, 0);
    check({tag, "_vcid"}, tx_vcid, 0);
    check({tag, "_flit_type"}, tx_flit_type, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_word_cnt"}, word_cnt, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat; checks hold-while-stalled.
  initial begin
    logic         stall_prev;
    logic [127:0] h_data;
    logic [15:0]  h_keep;
    logic         h_last;
    logic [5:0]   h_vcid;
    stall_prev = 1'b0;
    h_data = '0;
    h_keep = '0;
    h_last = 1'b0;
    h_vcid = '0;
    forever begin
      @(negedge tx_clk);
      if (!tx_arst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_tvalid", tx_tvalid, 1);
          check("stall_tdata", tx_tdata, h_data);
          check("stall_tkeep", tx_tkeep, h_keep);
          check("stall_tlast", tx_tlast, h_last);
          check("stall_vcid", tx_vcid, h_vcid);
        end
        stall_prev = tx_tvalid && !tx_tready;
        h_data = tx_tdata;
        h_keep = tx_tkeep;
        h_last = tx_tlast;
        h_vcid = tx_vcid;
        if (tx_tvalid && tx_tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", tx_tdata);
          end else begin
            mon_b = exp_q.pop_front();
            check("beat_tdata", tx_tdata, mon_b.data);
            check("beat_tkeep", tx_tkeep, mon_b.keep);
            check("beat_tlast", tx_tlast, mon_b.last);
            check("beat_vcid", tx_vcid, mon_b.vcid);
            check("beat_flit_type", tx_flit_type, mon_b.ft);
            check("beat_busy", busy, 1);
          end
          beats_seen++;
          if (tx_tlast) frames_seen++;
        end
      end
    end
  end

  // Sink ready: steady, random, or a 5-cycle stall on the first 'B' beat when armed.
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge tx_clk);
      #2;
      if (stall_left > 0) begin
        tx_tready = 1'b0;
        stall_left--;
        if (stall_left == 2) check("stall_word_cnt", word_cnt, 1);
      end else if (stall_on_b && tx_tvalid && (tx_tdata[7:0] == 8'h42)) begin
        tx_tready  = 1'b0;
        stall_left = 4;
        stall_on_b = 1'b0;
      end else begin
        tx_tready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Runs nfr frames; lim!=0 stops via frame_limit, else enable drops during the last frame.
  task automatic run(input logic [1:0] md, input int bl, input int nfr, input int lim,
                     input int drop_beats, input string tag);
    int q0, nb, b0, f0, cyc;
    q0 = exp_q.size();
    for (int i = 0; i < nfr; i++) gen_frame(md, bl);
    nb = exp_q.size() - q0;
    b0 = beats_seen;
    f0 = frames_seen;
    mode        = md;
    burst_len   = 8'(bl);
    frame_limit = CNT_W'(lim);
    enable      = 1'b1;
    @(posedge tx_clk);
    #1;
    cyc = 0;
    if (lim == 0) begin
      while (!((frames_seen - f0 >= nfr - 1) && (beats_seen - b0 >= drop_beats)) &&
             (cyc < BOUND)) begin
        @(posedge tx_clk);
        #1;
        cyc++;
      end
      enable = 1'b0;
      cyc = 0;
      while (!((frames_seen - f0 == nfr) && !busy) && (cyc < BOUND)) begin
        @(posedge tx_clk);
        #1;
        cyc++;
      end
      check({tag, "_timeout"}, (cyc >= BOUND), 0);
      check({tag, "_idle_tvalid"}, tx_tvalid, 0);
    end else begin
      while (!done && (cyc < BOUND)) begin
        @(posedge tx_clk);
        #1;
        cyc++;
      end
      check({tag, "_timeout"}, (cyc >= BOUND), 0);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_tvalid"}, tx_tvalid, 0);
    end
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_word_cnt"}, word_cnt, min_sat(nb));
    check({tag, "_frame_cnt"}, frame_cnt, min_sat(nfr));
    check({tag, "_vcid"}, tx_vcid, m_vcid);
    check({tag, "_flit_type"}, tx_flit_type, m_ft);
    if (lim != 0) begin
      enable = 1'b0;
      @(posedge tx_clk);
      #1;
      check({tag, "_done_clear"}, done, 0);
      check({tag, "_busy_clear"}, busy, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    int b0, cyc;
    tx_arst_n   = 1'b0;
    enable      = 1'b0;
    mode        = 2'd0;
    burst_len   = 8'd0;
    frame_limit = '0;
    model_reset();
    #3;
    chk_reset("por");
    repeat (2) @(posedge tx_clk);
    #3;
    tx_arst_n = 1'b1;
    repeat (3) @(posedge tx_clk);
    #1;
    chk_reset("release");

    // Reset in the middle of a burst frame aborts at once.
    gen_frame(2'd2, 3);
    b0 = beats_seen;
    mode      = 2'd2;
    burst_len = 8'd3;
    enable    = 1'b1;
    cyc = 0;
    do begin
      @(posedge tx_clk);
      #1;
      cyc++;
    end while ((beats_seen - b0 < 2) && (cyc < BOUND));
    check("midreset_timeout", (cyc >= BOUND), 0);
    #2;
    tx_arst_n = 1'b0;
    enable    = 1'b0;
    #1;
    chk_reset("midreset");
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge tx_clk);
    #3;
    tx_arst_n = 1'b1;
    repeat (3) @(posedge tx_clk);
    #1;
    chk_reset("midreset_release");

    // Burst of 3 with a stall on 'B'
    stall_on_b = 1'b1;
    run(2'd2, 3, 1, 0, 0, "burst");
    check("burst_vcid_is_1", tx_vcid, 1);
    check("burst_word_is_4", word_cnt, 4);

    // Enable dropped after the second DATA beat, then re-enabled
    run(2'd2, 3, 1, 0, 2, "drop");
    repeat (3) @(posedge tx_clk);
    #1;
    check("drop_stays_idle", tx_tvalid, 0);
    run(2'd2, 3, 1, 0, 0, "reenable");

    run(2'd1, 0, 5, 5, 0, "limit");

    // Idle mode never leaves IDLE
    mode   = 2'd3;
    enable = 1'b1;
    repeat (4) @(posedge tx_clk);
    #1;
    check("mode3_busy", busy, 0);
    check("mode3_tvalid", tx_tvalid, 0);
    enable = 1'b0;

    run(2'd2, 27, 1, 0, 0, "wrap");

    bp_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int md, nfr;
      md  = $urandom_range(0, 2);
      nfr = $urandom_range(1, 4);
      run(2'(md), $urandom_range(0, 6), nfr, ($urandom_range(0, 1) == 1) ? nfr : 0, 0, "rand");
    end
    bp_rand = 1'b0;
    repeat (2) @(posedge tx_clk);

    run(2'd2, 0, 70, 0, 0, "vcid_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
